// File: rtl/mux_sel_arbiter_if.sv
// rtl/mux_sel_arbiter_if.sv - request/grant/select bundle between two requesters and the mux arbiter
interface mux_sel_arbiter_if;
    logic req_a;
    logic req_b;
    logic gnt_a;
    logic gnt_b;
    logic sel;
    logic preempt;
    logic busy;

    modport master (
        output req_a, req_b,
        input  gnt_a, gnt_b, sel, preempt, busy
    );

    modport slave (
        input  req_a, req_b,
        output gnt_a, gnt_b, sel, preempt, busy
    );
endinterface

// File: rtl/mux_sel_arbiter.sv
// rtl/mux_sel_arbiter.sv - two-requester mux-select arbiter with hold limit and inter-owner gap
module mux_sel_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int GAP      = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_sel_arbiter_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_OWN_A, ST_OWN_B, ST_GAP} state_t;

    localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    localparam logic [3:0] GAP_LAST  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam bit         HAS_GAP   = (GAP > 0);

    state_t     state, state_nxt;
    logic [7:0] hold_cnt, hold_nxt;
    logic [3:0] gap_cnt, gap_nxt;
    logic       last_a, last_a_nxt;
    logic       gnt_a_q, gnt_b_q, sel_q, preempt_q, busy_q;
    logic       sel_nxt, preempt_nxt;

    // Tie goes to whoever did not own last; a preempted owner is always last_a's side.
    function automatic state_t arbitrate(input logic ra, input logic rb, input logic la);
        if (ra && rb)
            return la ? ST_OWN_B : ST_OWN_A;
        else if (ra)
            return ST_OWN_A;
        else if (rb)
            return ST_OWN_B;
        else
            return ST_IDLE;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            hold_cnt  <= 8'd0;
            gap_cnt   <= 4'd0;
            last_a    <= 1'b0;
            gnt_a_q   <= 1'b0;
            gnt_b_q   <= 1'b0;
            sel_q     <= 1'b1;
            preempt_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_nxt;
            gap_cnt   <= gap_nxt;
            last_a    <= last_a_nxt;
            gnt_a_q   <= (state_nxt == ST_OWN_A);
            gnt_b_q   <= (state_nxt == ST_OWN_B);
            sel_q     <= sel_nxt;
            preempt_q <= preempt_nxt;
            busy_q    <= (state_nxt != ST_IDLE);
        end
    end

    always_comb begin
        state_nxt   = state;
        preempt_nxt = 1'b0;
        case (state)
            ST_IDLE: state_nxt = arbitrate(bus.req_a, bus.req_b, last_a);
            ST_OWN_A: begin
                if (!bus.req_a) begin
                    state_nxt = HAS_GAP ? ST_GAP : (bus.req_b ? ST_OWN_B : ST_IDLE);
                end else if (bus.req_b && hold_cnt >= HOLD_LAST) begin
                    preempt_nxt = 1'b1;
                    state_nxt   = HAS_GAP ? ST_GAP : ST_OWN_B;
                end
            end
            ST_OWN_B: begin
                if (!bus.req_b) begin
                    state_nxt = HAS_GAP ? ST_GAP : (bus.req_a ? ST_OWN_A : ST_IDLE);
                end else if (bus.req_a && hold_cnt >= HOLD_LAST) begin
                    preempt_nxt = 1'b1;
                    state_nxt   = HAS_GAP ? ST_GAP : ST_OWN_A;
                end
            end
            ST_GAP: begin
                if (gap_cnt >= GAP_LAST)
                    state_nxt = arbitrate(bus.req_a, bus.req_b, last_a);
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Counters clear whenever the state is entered anew, including an A<->B handover.
    always_comb begin
        hold_nxt   = 8'd0;
        gap_nxt    = 4'd0;
        last_a_nxt = last_a;
        sel_nxt    = sel_q;
        if ((state_nxt == ST_OWN_A || state_nxt == ST_OWN_B) && state_nxt == state)
            hold_nxt = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 8'd1;
        if (state_nxt == ST_GAP && state == ST_GAP)
            gap_nxt = (gap_cnt == 4'hF) ? gap_cnt : gap_cnt + 4'd1;
        if (state_nxt == ST_OWN_A) begin
            last_a_nxt = 1'b1;
            sel_nxt    = 1'b1;
        end else if (state_nxt == ST_OWN_B) begin
            last_a_nxt = 1'b0;
            sel_nxt    = 1'b0;
        end
    end

    assign bus.gnt_a   = gnt_a_q;
    assign bus.gnt_b   = gnt_b_q;
    assign bus.sel     = sel_q;
    assign bus.preempt = preempt_q;
    assign bus.busy    = busy_q;
endmodule

// File: doc/mux_sel_arbiter.md
MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8: maximum consecutive grant cycles an owner keeps while the other requester waits; legal range 1..255.
REQ-002 Parameter GAP, default 1: idle cycles inserted between one ownership and the next; legal range 0..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_a  input  1  requester A wants the mux path (level, held until done).
REQ-006 req_b  input  1  requester B wants the mux path (level, held until done).
REQ-007 gnt_a  output  1  A owns the path.
REQ-008 gnt_b  output  1  B owns the path.
REQ-009 sel  output  1  mux select; 1 = path A, 0 = path B.
REQ-010 preempt  output  1  one-cycle pulse when an owner is cut off by the MAX_HOLD limit.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 The block SHALL use states IDLE, OWN_A, OWN_B and GAP, all registered; every output SHALL be driven from registers.
REQ-013 gnt_a and gnt_b SHALL never both be 1 in the same cycle.
REQ-014 sel SHALL change only on the same edge that asserts gnt_a (sel=1) or gnt_b (sel=0); it SHALL hold its value in IDLE and GAP.
REQ-015 A last_owner register SHALL record the most recent owner; on a tie (req_a=req_b=1), arbitration SHALL grant the requester that is not last_owner.
REQ-016 IDLE: on sampling req_x=1, the block SHALL enter OWN_x on the next edge (grant latency 1 cycle); with no request it SHALL stay in IDLE.
REQ-017 OWN_x: hold_cnt SHALL clear on entry and increment each cycle, saturating at MAX_HOLD.
REQ-018 OWN_x: if req_x=0, the owner SHALL release. The block SHALL go to GAP when GAP>0. When GAP=0, it SHALL go directly to OWN_other if the other request is pending, else to IDLE.
REQ-019 OWN_x: if req_x=1, the other request is pending and hold_cnt=MAX_HOLD-1, the block SHALL preempt. preempt SHALL pulse on the edge that drops gnt_x. The next state SHALL follow the REQ-018 path, with the other requester granted regardless of last_owner.
REQ-020 OWN_x with req_x=1 and no competing request SHALL hold indefinitely; preempt SHALL stay 0.
REQ-021 GAP SHALL last exactly GAP cycles with both grants 0. On exit, arbitration SHALL follow REQ-015/REQ-016, and a preempted requester SHALL have lower priority than the waiter.
REQ-022 A requester dropping its request during GAP SHALL lose the slot; if no request remains, the block SHALL return to IDLE.
REQ-023 gap_cnt SHALL be 4 bits wide; hold_cnt SHALL be 8 bits wide; neither counter SHALL wrap.

Reset
REQ-024 When rst_n=0, state SHALL be IDLE, gnt_a=0, gnt_b=0, sel=1, preempt=0, busy=0, last_owner=B, and counters SHALL be 0, all asynchronously.
REQ-025 Reset asserted mid-ownership SHALL drop the grant immediately without waiting for a clock edge. After deassertion, the first grant SHALL go to A on a tie.
REQ-026 The first edge after rst_n rises SHALL be a normal arbitration edge.

Verification
REQ-027 Reset, then req_a=1 at cycle 0 -> gnt_a=1, sel=1 at cycle 1; req_a=0 at cycle 5 -> gnt_a=0 at cycle 6, GAP for 1 cycle, then IDLE.
REQ-028 Reset, then req_a=req_b=1 together -> A is granted first. A releases -> after 1 GAP cycle, gnt_b=1 and sel=0.
REQ-029 MAX_HOLD=8, req_a held, req_b raised while A is owner -> gnt_a high for exactly 8 cycles, preempt pulses once, 1 GAP cycle, then gnt_b=1 with req_a still 1.
REQ-030 GAP=0, A owns and releases while req_b=1 -> gnt_a falls and gnt_b rises on the same edge; sel goes 1->0 on that edge; no cycle has both grants high.
REQ-031 rst_n pulsed low for 2 cycles while gnt_b=1 -> gnt_b=0 without a clock edge and sel=1. After release, with both requests high, A is granted first.
REQ-032 Random req_a/req_b for 10k cycles -> grants mutually exclusive, sel matches the active grant, and no waiter exceeds MAX_HOLD+GAP+1 cycles once the owner holds.
